// File: rtl/lstm_seq_ctrl_if.sv
// Handshake and data bundle between the LSTM sequencer, its cell, the input
// stream and the downstream consumer. The slave side is the sequencer.
interface lstm_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  seq_len;
  logic [DATA_WIDTH-1:0] c_init;
  logic [DATA_WIDTH-1:0] h_init;
  logic                  x_valid;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] cell_x;
  logic [DATA_WIDTH-1:0] cell_c_in;
  logic [DATA_WIDTH-1:0] cell_h_in;
  logic [DATA_WIDTH-1:0] cell_c_out;
  logic [DATA_WIDTH-1:0] cell_h_out;
  logic                  h_valid;
  logic                  h_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic                  h_last;
  logic [DATA_WIDTH-1:0] c_final;
  logic [DATA_WIDTH-1:0] h_final;
  logic                  busy;
  logic                  done;

  modport master (
    output start, seq_len, c_init, h_init, x_valid, x_data,
           cell_c_out, cell_h_out, h_ready,
    input  x_ready, cell_x, cell_c_in, cell_h_in, h_valid, h_data, h_last,
           c_final, h_final, busy, done
  );

  modport slave (
    input  start, seq_len, c_init, h_init, x_valid, x_data,
           cell_c_out, cell_h_out, h_ready,
    output x_ready, cell_x, cell_c_in, cell_h_in, h_valid, h_data, h_last,
           c_final, h_final, busy, done
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencer for a combinational LSTM cell: owns the recurrent (c, h) state,
// drives the cell from registers and streams one h word per timestep.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRACT_WIDTH   = 8,
  parameter int LEN_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  lstm_seq_ctrl_if.slave  bus_io
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_params
    $error("lstm_seq_ctrl: SETTLE_CYCLES must be >= 1 and FRACT_WIDTH < DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic [DATA_WIDTH-1:0] h_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  step_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  x_ready_q;
  logic                  h_valid_q;
  logic                  h_last_q;
  logic                  busy_q;
  logic                  done_q;

  // Every status output is its own flop, updated on the transition into the
  // state that owns it, so nothing downstream sees decode glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      c_q       <= '0;
      h_q       <= '0;
      len_q     <= '0;
      step_q    <= '0;
      settle_q  <= '0;
      x_ready_q <= 1'b0;
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_io.start) begin
            c_q    <= bus_io.c_init;
            h_q    <= bus_io.h_init;
            step_q <= '0;
            len_q  <= bus_io.seq_len;
            busy_q <= 1'b1;
            if (bus_io.seq_len != '0) begin
              x_ready_q <= 1'b1;
              state_q   <= S_LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (bus_io.x_valid) begin
            x_q       <= bus_io.x_data;
            settle_q  <= SETTLE_W'(SETTLE_CYCLES - 1);
            x_ready_q <= 1'b0;
            state_q   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - SETTLE_W'(1);
          end else begin
            c_q       <= bus_io.cell_c_out;
            h_q       <= bus_io.cell_h_out;
            h_valid_q <= 1'b1;
            h_last_q  <= (step_q == len_q - LEN_WIDTH'(1));
            state_q   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus_io.h_ready) begin
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            if (h_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              step_q    <= step_q + LEN_WIDTH'(1);
              x_ready_q <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.x_ready   = x_ready_q;
  assign bus_io.cell_x    = x_q;
  assign bus_io.cell_c_in = c_q;
  assign bus_io.cell_h_in = h_q;
  assign bus_io.h_valid   = h_valid_q;
  assign bus_io.h_data    = h_q;
  assign bus_io.h_last    = h_last_q;
  assign bus_io.c_final   = c_q;
  assign bus_io.h_final   = h_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a stub cell computing c_in + x.
module tb_lstm_seq_ctrl;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lstm_seq_ctrl_if #(.DATA_WIDTH(16), .LEN_WIDTH(8)) bus ();

  lstm_seq_ctrl #(
    .DATA_WIDTH(16), .FRACT_WIDTH(8), .LEN_WIDTH(8), .SETTLE_CYCLES(1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  assign bus.cell_c_out = bus.cell_c_in + bus.cell_x;
  assign bus.cell_h_out = bus.cell_c_in + bus.cell_x;

  always #5 clk_i = ~clk_i;

  logic [15:0] xs [0:3];
  int          x_idx;
  logic        hv [0:31];
  logic        hl [0:31];
  logic        dn [0:31];
  logic        xr [0:31];
  logic        bz [0:31];
  logic [15:0] hd [0:31];
  logic [15:0] cx [0:31];
  logic [15:0] cf [0:31];
  logic [15:0] hf [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs ncyc cycles from the start cycle (cycle 0), recording outputs per cycle.
  task automatic run(input int ncyc, input int st_lo, input int st_hi,
                     input int gp_lo, input int gp_hi, input int sp);
    logic fire;
    x_idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.start = (c == 0) || (c == sp);
      if (c == sp) bus.c_init = 16'h0777;
      bus.x_valid = !(c >= gp_lo && c <= gp_hi);
      bus.h_ready = !(c >= st_lo && c <= st_hi);
      bus.x_data  = xs[x_idx];
      hv[c] = bus.h_valid;  hl[c] = bus.h_last;  dn[c] = bus.done;
      xr[c] = bus.x_ready;  bz[c] = bus.busy;    hd[c] = bus.h_data;
      cx[c] = bus.cell_x;   cf[c] = bus.c_final; hf[c] = bus.h_final;
      fire = bus.x_valid && bus.x_ready;
      @(posedge clk_i); #1;
      if (fire && x_idx < 3) x_idx++;
      $display("cyc=%0d start=%0b xr=%0b hv=%0b hd=%h hl=%0b done=%0b",
               c, bus.start, xr[c], hv[c], hd[c], hl[c], dn[c]);
    end
    bus.start = 1'b0;
  endtask

  task automatic setup(input logic [7:0] len, input logic [15:0] cinit);
    bus.seq_len = len;
    bus.c_init  = cinit;
    bus.h_init  = 16'h0000;
  endtask

  int n_hv, n_hl, n_dn, n_xr;

  initial begin
    xs[0] = 16'h0010; xs[1] = 16'h0020; xs[2] = 16'h0030; xs[3] = 16'h0000;
    bus.start = 0; bus.seq_len = 0; bus.c_init = 0; bus.h_init = 0;
    bus.x_valid = 0; bus.x_data = 0; bus.h_ready = 0;

    // Reset: all outputs zero while held
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_x_ready", bus.x_ready, 0);
    chk("rst_h_valid", bus.h_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_h_last", bus.h_last, 0);
    chk("rst_cell_x", bus.cell_x, 0);
    chk("rst_cell_c_in", bus.cell_c_in, 0);
    chk("rst_cell_h_in", bus.cell_h_in, 0);
    chk("rst_h_data", bus.h_data, 0);
    chk("rst_c_final", bus.c_final, 0);
    chk("rst_h_final", bus.h_final, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_x_ready", bus.x_ready, 0);

    // Nominal
    setup(8'd3, 16'h0100);
    run(12, -1, -1, -1, -1, -1);
    n_hv = 0; n_hl = 0; n_dn = 0;
    for (int c = 0; c < 12; c++) begin
      n_hv += int'(hv[c]); n_hl += int'(hl[c]); n_dn += int'(dn[c]);
    end
    chk("nom_x_ready_c0", xr[0], 0);
    chk("nom_x_ready_c1", xr[1], 1);
    chk("nom_busy_c1", bz[1], 1);
    chk("nom_hv_c3", hv[3], 1);
    chk("nom_hd_c3", hd[3], 16'h0110);
    chk("nom_hd_c6", hd[6], 16'h0130);
    chk("nom_hd_c9", hd[9], 16'h0160);
    chk("nom_hl_c9", hl[9], 1);
    chk("nom_hl_count", n_hl, 1);
    chk("nom_hv_count", n_hv, 3);
    chk("nom_done_c10", dn[10], 1);
    chk("nom_done_count", n_dn, 1);
    chk("nom_c_final", cf[11], 16'h0160);
    chk("nom_h_final", hf[11], 16'h0160);
    chk("nom_busy_c11", bz[11], 0);

    // Backpressure: h_ready low cycles 6..10
    setup(8'd3, 16'h0100);
    run(17, 6, 10, -1, -1, -1);
    for (int c = 6; c <= 10; c++) begin
      chk($sformatf("bp_hv_c%0d", c), hv[c], 1);
      chk($sformatf("bp_hd_c%0d", c), hd[c], 16'h0130);
      chk($sformatf("bp_xr_c%0d", c), xr[c], 0);
      chk($sformatf("bp_hl_c%0d", c), hl[c], 0);
    end
    chk("bp_xr_c12", xr[12], 1);
    chk("bp_cx_c13", cx[13], 16'h0030);
    chk("bp_hd_c14", hd[14], 16'h0160);
    chk("bp_hl_c14", hl[14], 1);
    chk("bp_done_c14", dn[14], 0);
    chk("bp_done_c15", dn[15], 1);
    chk("bp_c_final", cf[16], 16'h0160);

    // Input gap: x_valid low cycles 4..7
    setup(8'd3, 16'h0100);
    run(16, -1, -1, 4, 7, -1);
    chk("gap_xr_c7", xr[7], 1);
    chk("gap_cx_c7", cx[7], 16'h0010);
    chk("gap_hv_c6", hv[6], 0);
    chk("gap_hd_c3", hd[3], 16'h0110);
    chk("gap_hd_c10", hd[10], 16'h0130);
    chk("gap_hd_c13", hd[13], 16'h0160);
    chk("gap_hl_c13", hl[13], 1);
    chk("gap_done_c14", dn[14], 1);

    // Zero length
    setup(8'd0, 16'h0A00);
    run(4, -1, -1, -1, -1, -1);
    n_hv = 0; n_xr = 0;
    for (int c = 0; c < 4; c++) begin
      n_hv += int'(hv[c]); n_xr += int'(xr[c]);
    end
    chk("zero_done_c1", dn[1], 1);
    chk("zero_done_c2", dn[2], 0);
    chk("zero_hv_count", n_hv, 0);
    chk("zero_xr_count", n_xr, 0);
    chk("zero_c_final", cf[2], 16'h0A00);

    // Abuse: start pulsed during EVAL (cycle 2) with different c_init
    setup(8'd3, 16'h0100);
    run(13, -1, -1, -1, -1, 2);
    n_dn = 0;
    for (int c = 0; c < 13; c++) n_dn += int'(dn[c]);
    chk("ab_hd_c3", hd[3], 16'h0110);
    chk("ab_hd_c6", hd[6], 16'h0130);
    chk("ab_hd_c9", hd[9], 16'h0160);
    chk("ab_done_c10", dn[10], 1);
    chk("ab_done_count", n_dn, 1);
    chk("ab_busy_c12", bz[12], 0);

    // Abuse: reset asserted while in EMIT
    setup(8'd3, 16'h0100);
    run(3, -1, -1, -1, -1, -1);
    chk("rstemit_hv_before", bus.h_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstemit_hv", bus.h_valid, 0);
    chk("rstemit_busy", bus.busy, 0);
    chk("rstemit_c_final", bus.c_final, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    n_dn = 0;
    for (int c = 0; c < 6; c++) begin
      n_dn += int'(bus.done);
      @(posedge clk_i); #1;
    end
    chk("rstemit_done_count", n_dn, 0);
    chk("rstemit_busy_after", bus.busy, 0);
    chk("rstemit_x_ready_after", bus.x_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer that runs the combinational LSTM cell over a sequence of `seq_len` timesteps. It owns the recurrent state registers (c, h) and presents registered `X`, `c_in` and `h_in` to the cell. It captures the cell's `c_out`/`h_out` after a programmable settle time and streams each step's h out through a valid/ready handshake. It sits between the input-sample stream and the downstream consumer, with the cell instantiated beside it.

## Interface
- `DATA_WIDTH`, 16, width of all data words (Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH)
- `FRACT_WIDTH`, 8, fractional bits; not used arithmetically here, documents format
- `LEN_WIDTH`, 8, width of sequence length / step counter
- `SETTLE_CYCLES`, 1, cycles the cell inputs are held stable before capture (≥1)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sequence; sampled only in IDLE
- `seq_len`  in  LEN_WIDTH  number of timesteps; latched on accepted start
- `c_init`, `h_init`  in  DATA_WIDTH  initial cell/hidden state; latched on accepted start
- `x_valid`  in  1  input sample available
- `x_data`  in  DATA_WIDTH  input sample X
- `x_ready`  out  1  controller accepts X this cycle
- `cell_x`, `cell_c_in`, `cell_h_in`  out  DATA_WIDTH  registered drive to the cell
- `cell_c_out`, `cell_h_out`  in  DATA_WIDTH  cell results (combinational from cell inputs)
- `h_valid`  out  1  step output valid
- `h_ready`  in  1  downstream accepts h
- `h_data`  out  DATA_WIDTH  hidden state of current step
- `h_last`  out  1  qualifies final step (valid only with `h_valid`)
- `c_final`, `h_final`  out  DATA_WIDTH  state after last step, held until next accepted start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at sequence end

## Operation
- States: IDLE, LOAD, EVAL, EMIT, DONE.
- IDLE: on `start`:
  - `seq_len`≠0: latch len, c_reg←`c_init`, h_reg←`h_init`, step←0, →LOAD.
  - `seq_len`==0: c_reg←`c_init`, h_reg←`h_init`, →DONE.
- LOAD: `x_ready`=1. On `x_valid`: x_reg←`x_data`, settle←SETTLE_CYCLES-1, →EVAL.
- EVAL: cell inputs stable. If settle≠0, decrement. If settle==0: c_reg←`cell_c_out`, h_reg←`cell_h_out`, →EMIT.
- EMIT: `h_valid`=1, `h_data`=h_reg, `h_last`=(step==len-1). On `h_ready`:
  - last step: →DONE.
  - otherwise: step←step+1, →LOAD.
- DONE: `done`=1 for exactly one cycle, →IDLE.
- `cell_x`=x_reg, `cell_c_in`=c_reg, `cell_h_in`=h_reg at all times.
- `c_final`=c_reg and `h_final`=h_reg; meaningful once `done` has pulsed.
- `start` outside IDLE is ignored; it does not queue.
- No arithmetic in this block. Captured values are stored verbatim with no saturation or rounding.

## Timing
- Reset (async, `rst`=0): state IDLE; every output and register is 0, including `x_ready`, `h_valid`, `done`, `busy`, cell drives, `c_final`, `h_final`.
- Reset asserted mid-sequence: return to IDLE immediately; partial state is discarded; no `done`.
- Per step with `x_valid` and `h_ready` held high: 1 LOAD + SETTLE_CYCLES EVAL + 1 EMIT cycle (3 cycles at default).
- With `start` accepted at cycle 0:
  - `x_ready` is high at cycle 1.
  - First `h_valid` is at cycle 2+SETTLE_CYCLES.
  - `done` is high one cycle after the last EMIT handshake.
- `h_valid`, `h_data` and `h_last` stay stable while `h_ready`=0. `x_ready`=0 outside LOAD, so backpressure stalls input consumption.
- `x_valid`=0 in LOAD: wait indefinitely; cell inputs keep their previous values.
- Step counter never wraps: len ≤ 2^LEN_WIDTH−1 and the counter stops at len−1.

## Test plan
Bench cell stub: `cell_c_out` = `cell_h_out` = `cell_c_in`+`cell_x`.
- Reset: hold `rst`=0 → all outputs 0. Release, idle 5 cycles → `busy`=0, `x_ready`=0.
- Nominal: `seq_len`=3, `c_init`=0x0100, `h_init`=0; X = 0x0010, 0x0020, 0x0030 always valid; `h_ready`=1; start at cycle 0.
  - `h_data` = 0x0110 @3, 0x0130 @6, 0x0160 @9; `h_last` only @9.
  - `done` @10; `c_final`=`h_final`=0x0160.
- Backpressure: same stimulus but `h_ready`=0 for cycles 6–10.
  - `h_data` holds 0x0130 and `x_ready`=0 during the stall.
  - Third X is accepted at cycle 12; `done` at cycle 15.
- Input gaps: `x_valid` low for 4 cycles before the second sample → FSM waits in LOAD; `h_data` sequence is unchanged.
- Zero length: `seq_len`=0, `c_init`=0x0A00 → `done` at cycle 1, no `h_valid`, `x_ready` never high, `c_final`=0x0A00.
- Abuse:
  - `start` pulsed during EVAL is ignored; the sequence completes normally.
  - `rst` low during EMIT drops `h_valid` immediately; after release the block is in IDLE and `done` never pulsed.
